video_stream_gen: RTL and testbench
===================================

Name: video_stream_gen

Overview:
- Transmitter end of the per_img_vsync / per_img_href / per_img_gray pixel-stream interface consumed by the filter and binarization blocks.
- Reads 8-bit gray pixels from a show-ahead FIFO and emits them with programmable line and frame blanking.
- Sits between the frame-buffer read path and the first processing stage; also serves as the bench stimulus source.

Parameters:
- IMG_H_DISP, 640, active pixels per line.
- IMG_V_DISP, 480, active lines per frame.
- H_BLANK, 16, idle cycles after every active line (href low, vsync high).
- V_LEAD, 8, cycles with vsync high before the first line.
- V_BLANK, 32, cycles with vsync low between frames.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  level; permits a new frame to start.
- clr_status  in  1  single-cycle pulse; clears underflow.
- pattern_sel  in  1  test-pattern select; used only under the macro.
- src_empty  in  1  FIFO empty flag.
- src_data  in  8  FIFO show-ahead head word.
- src_rd  out  1  FIFO read strobe.
- per_img_vsync  out  1  frame valid, active high.
- per_img_href  out  1  line valid, active high.
- per_img_gray  out  8  pixel.
- frame_done  out  1  one-cycle pulse.
- underflow  out  1  sticky error flag.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; all counters 0.
- FSM states and transitions:
  - IDLE -> V_LEAD when enable=1.
  - V_LEAD (V_LEAD cycles) -> ACTIVE.
  - ACTIVE (IMG_H_DISP cycles) -> HBLANK.
  - HBLANK (H_BLANK cycles) -> ACTIVE, or -> V_BLANK after the last line's HBLANK.
  - V_BLANK (V_BLANK cycles) -> V_LEAD if enable=1, else IDLE.
- Counters:
  - One down-counter per state, reloaded on state entry.
  - Line counter wraps 0..IMG_V_DISP-1.
  - Pixel counter is $clog2(IMG_H_DISP) bits and wraps 0..IMG_H_DISP-1.
- Outputs are registered one cycle behind state:
  - per_img_vsync <= state in {V_LEAD, ACTIVE, HBLANK}.
  - per_img_href <= state==ACTIVE.
  - per_img_gray <= selected pixel while ACTIVE, else 0.
- src_rd is combinational: (state==ACTIVE) && !src_empty. Pixel latency: FIFO head to output is 1 cycle.
- Underflow: src_empty=1 in an ACTIVE cycle.
  - That pixel outputs 0.
  - Timing is not stretched; the line keeps its length.
  - underflow is set the next cycle and holds until clr_status or reset.
  - If clr_status and a new underflow occur in the same cycle, set wins.
- frame_done: pulses for 1 cycle in the cycle after per_img_vsync falls.
- enable deasserted mid-frame: the current frame completes in full; return to IDLE after V_BLANK.
- Frame period: V_LEAD + IMG_V_DISP*(IMG_H_DISP+H_BLANK) + V_BLANK cycles.
- Reset mid-frame: outputs drop to 0 immediately (async). No partial frame resumes.

Optional Feature:
- Macro: VIDEO_STREAM_GEN_TEST_PATTERN_EN.
- Defined, pattern_sel=1:
  - per_img_gray = (pixel_cnt + line_cnt) modulo 256.
  - src_rd held 0; underflow never sets.
- Defined, pattern_sel=0: normal FIFO behaviour.
- Not defined: pattern_sel is ignored and the pattern logic is absent.

Test Plan (params IMG_H_DISP=4, IMG_V_DISP=2, H_BLANK=2, V_LEAD=3, V_BLANK=5):
- Reset, enable=1, FIFO preloaded with 8 words 10..17 -> vsync rises 1 cycle after IDLE exit.
  - href high 4 cycles with gray 10,11,12,13.
  - 2-cycle gap, then 14..17.
  - vsync high 3+12=15 cycles; frame_done pulses once.
  - Next frame vsync rises 5 cycles after vsync fell.
- enable held 1 with FIFO continuously refilled -> consecutive frames with period exactly 20 cycles; src_rd count = 8 per frame.
- FIFO empty on the 3rd pixel of line 0 -> that pixel outputs 0, line length still 4, underflow=1.
  - underflow stays 1 until clr_status pulse, then 0.
- enable dropped during line 1 -> frame finishes with 8 pixels, then IDLE; no further vsync.
- rst_n asserted during ACTIVE -> vsync/href/gray/src_rd 0 at once; after release with enable=1, a clean full frame follows.
- Macro defined, pattern_sel=1 -> line 0 gray 0,1,2,3; line 1 gray 1,2,3,4; src_rd never 1.

Source files
------------

// File: rtl/video_stream_gen.sv
// -----------------------------------------------------------------------------
// video_stream_gen
//
// Transmitter end of the per_img_vsync / per_img_href / per_img_gray pixel
// stream. Pulls 8-bit gray pixels from a show-ahead FIFO and emits them with
// programmable line blanking (href low, vsync high) and frame blanking
// (vsync low).
//
// Optional feature macro: VIDEO_STREAM_GEN_TEST_PATTERN_EN
//   When defined and pattern_sel=1, pixels are (pixel_cnt + line_cnt) mod 256,
//   the FIFO is never read and underflow never sets.
//
// Ports:
//   clk           in   pixel clock
//   rst_n         in   asynchronous active-low reset
//   enable        in   level, permits a new frame to start
//   clr_status    in   pulse, clears the sticky underflow flag
//   pattern_sel   in   test-pattern select (only used under the macro)
//   src_empty     in   FIFO empty flag
//   src_data[7:0] in   FIFO show-ahead head word
//   src_rd        out  FIFO read strobe (combinational)
//   per_img_vsync out  frame valid
//   per_img_href  out  line valid
//   per_img_gray  out  pixel value
//   frame_done    out  one-cycle pulse in the first cycle after vsync falls
//   underflow     out  sticky: FIFO was empty during an active pixel
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module video_stream_gen #(
  parameter int IMG_H_DISP = 640,
  parameter int IMG_V_DISP = 480,
  parameter int H_BLANK    = 16,
  parameter int V_LEAD     = 8,
  parameter int V_BLANK    = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       clr_status,
  input  logic       pattern_sel,
  input  logic       src_empty,
  input  logic [7:0] src_data,
  output logic       src_rd,
  output logic       per_img_vsync,
  output logic       per_img_href,
  output logic [7:0] per_img_gray,
  output logic       frame_done,
  output logic       underflow
);

  localparam int PIX_W  = (IMG_H_DISP > 1) ? $clog2(IMG_H_DISP) : 1;
  localparam int LINE_W = (IMG_V_DISP > 1) ? $clog2(IMG_V_DISP) : 1;

  // The shared state down-counter must hold the longest state duration.
  localparam int CNT_MAX_A = (V_LEAD > IMG_H_DISP) ? V_LEAD : IMG_H_DISP;
  localparam int CNT_MAX_B = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
  localparam int CNT_MAX   = (CNT_MAX_A > CNT_MAX_B) ? CNT_MAX_A : CNT_MAX_B;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]  CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  LD_VLEAD   = CNT_W'(V_LEAD - 1);
  localparam logic [CNT_W-1:0]  LD_ACTIVE  = CNT_W'(IMG_H_DISP - 1);
  localparam logic [CNT_W-1:0]  LD_HBLANK  = CNT_W'(H_BLANK - 1);
  localparam logic [CNT_W-1:0]  LD_VBLANK  = CNT_W'(V_BLANK - 1);
  localparam logic [PIX_W-1:0]  PIX_ZERO   = {PIX_W{1'b0}};
  localparam logic [PIX_W-1:0]  PIX_ONE    = {{(PIX_W-1){1'b0}}, 1'b1};
  localparam logic [PIX_W-1:0]  PIX_LAST   = PIX_W'(IMG_H_DISP - 1);
  localparam logic [LINE_W-1:0] LINE_ZERO  = {LINE_W{1'b0}};
  localparam logic [LINE_W-1:0] LINE_ONE   = {{(LINE_W-1){1'b0}}, 1'b1};
  localparam logic [LINE_W-1:0] LINE_LAST  = LINE_W'(IMG_V_DISP - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_VLEAD  = 3'd1,
    S_ACTIVE = 3'd2,
    S_HBLANK = 3'd3,
    S_VBLANK = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PIX_W-1:0]    pix_q, pix_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic                vsync_q, vsync_d;
  logic                href_q, href_d;
  logic [7:0]          gray_q, gray_d;
  logic                done_q, done_d;
  logic                uflow_q, uflow_d;

  logic                active_s;
  logic                pat_mode_s;
  logic [7:0]          pat_gray_s;
  logic                uf_event_s;

`ifdef VIDEO_STREAM_GEN_TEST_PATTERN_EN
  assign pat_mode_s = pattern_sel;
  // Truncating each operand to 8 bits first keeps the sum congruent mod 256.
  assign pat_gray_s = 8'(pix_q) + 8'(line_q);
`else
  logic unused_pattern_sel_s;
  assign unused_pattern_sel_s = pattern_sel;
  assign pat_mode_s           = 1'b0;
  assign pat_gray_s           = 8'h00;
`endif

  assign active_s   = (state_q == S_ACTIVE);
  // An empty FIFO during an active pixel is an underflow; the line is not stretched.
  assign uf_event_s = active_s && src_empty && !pat_mode_s;
  assign src_rd     = active_s && !src_empty && !pat_mode_s;

  // Next-state, counter and registered-output computation.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pix_d    = pix_q;
    line_d   = line_q;

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_VLEAD;
          cnt_d   = LD_VLEAD;
        end else begin
          cnt_d   = CNT_ZERO;
        end
      end
      S_VLEAD: begin
        if (cnt_q == CNT_ZERO) begin
          state_d = S_ACTIVE;
          cnt_d   = LD_ACTIVE;
        end else begin
          cnt_d   = cnt_q - CNT_ONE;
        end
      end
      S_ACTIVE: begin
        if (pix_q == PIX_LAST) begin
          pix_d = PIX_ZERO;
        end else begin
          pix_d = pix_q + PIX_ONE;
        end
        if (cnt_q == CNT_ZERO) begin
          state_d = S_HBLANK;
          cnt_d   = LD_HBLANK;
        end else begin
          cnt_d   = cnt_q - CNT_ONE;
        end
      end
      S_HBLANK: begin
        if (cnt_q == CNT_ZERO) begin
          if (line_q == LINE_LAST) begin
            line_d  = LINE_ZERO;
            state_d = S_VBLANK;
            cnt_d   = LD_VBLANK;
          end else begin
            line_d  = line_q + LINE_ONE;
            state_d = S_ACTIVE;
            cnt_d   = LD_ACTIVE;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_VBLANK: begin
        if (cnt_q == CNT_ZERO) begin
          if (enable) begin
            state_d = S_VLEAD;
            cnt_d   = LD_VLEAD;
          end else begin
            state_d = S_IDLE;
            cnt_d   = CNT_ZERO;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = CNT_ZERO;
        pix_d   = PIX_ZERO;
        line_d  = LINE_ZERO;
      end
    endcase

    // Outputs trail the state by one cycle.
    vsync_d = (state_q == S_VLEAD) || (state_q == S_ACTIVE) || (state_q == S_HBLANK);
    href_d  = active_s;

    if (!active_s) begin
      gray_d = 8'h00;
    end else if (pat_mode_s) begin
      gray_d = pat_gray_s;
    end else if (src_empty) begin
      gray_d = 8'h00;
    end else begin
      gray_d = src_data;
    end

    // Falling edge of the registered vsync, so the pulse lines up with the
    // first low cycle of per_img_vsync.
    done_d = vsync_q && !vsync_d;

    // A new underflow takes priority over a simultaneous clear.
    if (uf_event_s) begin
      uflow_d = 1'b1;
    end else if (clr_status) begin
      uflow_d = 1'b0;
    end else begin
      uflow_d = uflow_q;
    end
  end

  // State, counters and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= CNT_ZERO;
      pix_q   <= PIX_ZERO;
      line_q  <= LINE_ZERO;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      gray_q  <= 8'h00;
      done_q  <= 1'b0;
      uflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pix_q   <= pix_d;
      line_q  <= line_d;
      vsync_q <= vsync_d;
      href_q  <= href_d;
      gray_q  <= gray_d;
      done_q  <= done_d;
      uflow_q <= uflow_d;
    end
  end

  assign per_img_vsync = vsync_q;
  assign per_img_href  = href_q;
  assign per_img_gray  = gray_q;
  assign frame_done    = done_q;
  assign underflow     = uflow_q;

endmodule

// File: tb/tb_video_stream_gen.sv
`timescale 1ns/1ps

module tb_video_stream_gen;

  localparam int H      = 4;
  localparam int V      = 2;
  localparam int HB     = 2;
  localparam int VL     = 3;
  localparam int VB     = 5;
  localparam int LINE_T = H + HB;
  localparam int VS_T   = VL + V * LINE_T;   // cycles vsync is high
  localparam int PERIOD = VS_T + VB;         // frame period

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       clr_status = 1'b0;
  logic       pattern_sel = 1'b0;
  logic       src_empty = 1'b1;
  logic [7:0] src_data = 8'h00;
  logic       src_rd;
  logic       vsync;
  logic       href;
  logic [7:0] gray;
  logic       frame_done;
  logic       underflow;

  int checks = 0;
  int failures = 0;

  // FIFO model contents, and the scoreboard of words the DUT should emit.
  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  bit         force_empty = 1'b0;
  bit         rd_pend = 1'b0;

  video_stream_gen #(
    .IMG_H_DISP(H), .IMG_V_DISP(V), .H_BLANK(HB), .V_LEAD(VL), .V_BLANK(VB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clr_status(clr_status),
    .pattern_sel(pattern_sel), .src_empty(src_empty), .src_data(src_data),
    .src_rd(src_rd), .per_img_vsync(vsync), .per_img_href(href),
    .per_img_gray(gray), .frame_done(frame_done), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Read strobe is stable mid-cycle; remember it for the next edge.
  always @(negedge clk) rd_pend = src_rd;

  // Show-ahead FIFO: pop after the edge that consumed the head, then present the new head.
  always @(posedge clk) begin
    #1;
    if (rd_pend && fifo_q.size() > 0) void'(fifo_q.pop_front());
    src_empty = force_empty || (fifo_q.size() == 0);
    src_data  = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  task automatic push_word(input logic [7:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic wait_vsync_rise();
    bit ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (vsync === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL wait_vsync: vsync=%b required 1 within 60 cycles", vsync);
    end
  endtask

  // Checks one whole frame cycle by cycle from the first vsync-high cycle.
  // Expected waveform derives from frame geometry; pixel data from the scoreboard.
  task automatic check_frame(input int uf_pix, input bit pat, input bit push,
                             input int drop_at, input bit expect_next);
    int         rd_cnt = 0;
    int         exp_rd;
    int         stime;
    int         l;
    int         c;
    bit         exp_v;
    bit         exp_h;
    logic [7:0] exp_g;
    if (push) for (int k = 0; k < H * V; k++) push_word(8'($urandom_range(0, 255)));
    // Cycle, relative to the vsync rise, in which the DUT samples the chosen pixel.
    stime = (uf_pix >= 0) ? (VL - 1 + (uf_pix / H) * LINE_T + (uf_pix % H)) : -10;
    exp_rd = pat ? 0 : ((uf_pix >= 0) ? H * V - 1 : H * V);
    for (int t = 0; t < PERIOD; t++) begin
      if (t > 0) @(negedge clk);
      if (t == stime - 1) force_empty = 1'b1;
      if (t == stime) force_empty = 1'b0;
      if (t == drop_at) enable = 1'b0;
      exp_v = (t < VS_T);
      exp_h = exp_v && (t >= VL) && (((t - VL) % LINE_T) < H);
      exp_g = 8'h00;
      if (exp_h) begin
        l = (t - VL) / LINE_T;
        c = (t - VL) % LINE_T;
        if (pat) exp_g = 8'((c + l) % 256);
        else if (l * H + c == uf_pix) exp_g = 8'h00;
        else if (exp_q.size() > 0) exp_g = exp_q.pop_front();
        else exp_g = 8'h00;
      end
      checks++;
      if (vsync !== exp_v) begin
        failures++;
        $display("FAIL vsync t=%0d: got %b required %b", t, vsync, exp_v);
      end
      checks++;
      if (href !== exp_h) begin
        failures++;
        $display("FAIL href t=%0d: got %b required %b", t, href, exp_h);
      end
      checks++;
      if (gray !== exp_g) begin
        failures++;
        $display("FAIL gray t=%0d: got %0d required %0d", t, gray, exp_g);
      end
      checks++;
      if (frame_done !== (t == VS_T)) begin
        failures++;
        $display("FAIL frame_done t=%0d: got %b required %b", t, frame_done, (t == VS_T));
      end
      if (src_rd === 1'b1) rd_cnt++;
    end
    @(negedge clk);
    checks++;
    if (rd_cnt != exp_rd) begin
      failures++;
      $display("FAIL src_rd_count: got %0d required %0d", rd_cnt, exp_rd);
    end
    checks++;
    if (vsync !== expect_next) begin
      failures++;
      $display("FAIL next_frame_vsync: got %b required %b", vsync, expect_next);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({vsync, href, gray, src_rd, frame_done, underflow} !== 13'd0) begin
      failures++;
      $display("FAIL reset_outputs: got vs=%b hr=%b gr=%0d rd=%b fd=%b uf=%b required all 0",
               vsync, href, gray, src_rd, frame_done, underflow);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_first_frame();
    for (int i = 0; i < 8; i++) push_word(8'(10 + i));
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    checks++;
    if (vsync !== 1'b0) begin
      failures++;
      $display("FAIL vsync_idle_exit: got %b required 0", vsync);
    end
    @(negedge clk);
    checks++;
    if (vsync !== 1'b1) begin
      failures++;
      $display("FAIL vsync_rise: got %b required 1", vsync);
    end
    check_frame(-1, 1'b0, 1'b0, -1, 1'b1);
  endtask

  task automatic test_back_to_back();
    repeat (2) check_frame(-1, 1'b0, 1'b1, -1, 1'b1);
  endtask

  task automatic test_underflow();
    checks++;
    if (underflow !== 1'b0) begin
      failures++;
      $display("FAIL underflow_pre: got %b required 0", underflow);
    end
    check_frame(2, 1'b0, 1'b1, -1, 1'b1);
    checks++;
    if (underflow !== 1'b1) begin
      failures++;
      $display("FAIL underflow_set: got %b required 1", underflow);
    end
  endtask

  task automatic test_enable_drop();
    int highs = 0;
    check_frame(-1, 1'b0, 1'b1, LINE_T + VL, 1'b0);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (vsync !== 1'b0) highs++;
    end
    checks++;
    if (highs != 0) begin
      failures++;
      $display("FAIL idle_after_drop: got %0d vsync-high cycles required 0", highs);
    end
    checks++;
    if (underflow !== 1'b1) begin
      failures++;
      $display("FAIL underflow_sticky: got %b required 1", underflow);
    end
    clr_status = 1'b1;
    @(negedge clk);
    clr_status = 1'b0;
    checks++;
    if (underflow !== 1'b0) begin
      failures++;
      $display("FAIL underflow_clear: got %b required 0", underflow);
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < H * V; k++) push_word(8'($urandom_range(0, 255)));
    enable = 1'b1;
    wait_vsync_rise();
    repeat (VL + 1) @(negedge clk);
    checks++;
    if (href !== 1'b1) begin
      failures++;
      $display("FAIL href_before_reset: got %b required 1", href);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({vsync, href, gray, src_rd} !== 11'd0) begin
      failures++;
      $display("FAIL reset_async: got vs=%b hr=%b gr=%0d rd=%b required all 0",
               vsync, href, gray, src_rd);
    end
    @(negedge clk);
    fifo_q.delete();
    exp_q.delete();
    for (int k = 0; k < H * V; k++) push_word(8'($urandom_range(0, 255)));
    rst_n = 1'b1;
    wait_vsync_rise();
    check_frame(-1, 1'b0, 1'b0, LINE_T + VL, 1'b0);
  endtask

`ifdef VIDEO_STREAM_GEN_TEST_PATTERN_EN
  task automatic test_pattern();
    repeat (10) @(negedge clk);
    fifo_q.delete();
    exp_q.delete();
    pattern_sel = 1'b1;
    enable = 1'b1;
    wait_vsync_rise();
    check_frame(-1, 1'b1, 1'b0, LINE_T + VL, 1'b0);
    checks++;
    if (underflow !== 1'b0) begin
      failures++;
      $display("FAIL pattern_no_underflow: got %b required 0", underflow);
    end
    pattern_sel = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_first_frame();
    test_back_to_back();
    test_underflow();
    test_enable_drop();
    test_reset_mid();
`ifdef VIDEO_STREAM_GEN_TEST_PATTERN_EN
    test_pattern();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
